// File: rtl/sevenseg_pkg.sv
// Shared constants for the two-digit seven-segment scanner: active-low segment
// patterns, digit-slot state encoding and anode enables.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    DIG_UNITS = 1'b0,
    DIG_TENS  = 1'b1
  } dig_state_e;

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder ({g,f,e,d,c,b,a}).
// Non-BCD codes 10..15 show a dash so upstream faults are visible on the display.
module bcd_to_seg7
  import sevenseg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Two-digit multiplexed common-anode display driver; the shown pair only changes
// at frame boundaries. Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd_sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int CNT_W   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] tens_in,
  input  logic [3:0] units_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  logic [CNT_W-1:0] div_q, div_d;
  logic             tick;
  dig_state_e       state_q, state_d;
  logic [3:0]       shadow_tens_q, shadow_tens_d;
  logic [3:0]       shadow_units_q, shadow_units_d;
  logic [3:0]       disp_tens_q, disp_tens_d;
  logic [3:0]       disp_units_q, disp_units_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             frame_tick_q, frame_tick_d;
  logic [3:0]       digit_sel;
  logic [6:0]       dec_seg;

  assign tick   = (div_q == CNT_W'(CLK_DIV - 1));
  assign div_d  = tick ? '0 : div_q + CNT_W'(1);

  assign digit_sel = (state_q == DIG_TENS) ? disp_tens_q : disp_units_q;

  bcd_to_seg7 u_dec (
    .bcd_i (digit_sel),
    .seg_o (dec_seg)
  );

  always_comb begin
    state_d        = state_q;
    shadow_tens_d  = shadow_tens_q;
    shadow_units_d = shadow_units_q;
    disp_tens_d    = disp_tens_q;
    disp_units_d   = disp_units_q;
    frame_tick_d   = 1'b0;

    if (load) begin
      shadow_tens_d  = tens_in;
      shadow_units_d = units_in;
    end

    case (state_q)
      DIG_UNITS: if (tick) state_d = DIG_TENS;
      DIG_TENS: begin
        if (tick) begin
          state_d      = DIG_UNITS;
          frame_tick_d = 1'b1;
          // A load on the reload edge bypasses the shadow so it is not lost for a frame.
          disp_tens_d  = load ? tens_in  : shadow_tens_q;
          disp_units_d = load ? units_in : shadow_units_q;
        end
      end
      default: state_d = DIG_UNITS;
    endcase

    an_d  = (state_q == DIG_TENS) ? AN_TENS : AN_UNITS;
    seg_d = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
    if ((state_q == DIG_TENS) && (disp_tens_q == 4'd0)) seg_d = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q          <= '0;
      state_q        <= DIG_UNITS;
      shadow_tens_q  <= 4'd0;
      shadow_units_q <= 4'd0;
      disp_tens_q    <= 4'd0;
      disp_units_q   <= 4'd0;
      seg_q          <= SEG_BLANK;
      an_q           <= AN_OFF;
      frame_tick_q   <= 1'b0;
    end else begin
      div_q          <= div_d;
      state_q        <= state_d;
      shadow_tens_q  <= shadow_tens_d;
      shadow_units_q <= shadow_units_d;
      disp_tens_q    <= disp_tens_d;
      disp_units_q   <= disp_units_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Self-checking bench for bcd_sevenseg_scan with CLK_DIV=4; a frame-level model
// predicts seg/an/frame_tick after every clock edge. Honours LEADING_ZERO_BLANK_EN.
module tb_bcd_sevenseg_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 2 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] tens_in;
  logic [3:0] units_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  int         testsRun = 0;
  int         testsFailed = 0;
  int         n;
  int         lastTick;
  string      phase;
  logic [3:0] mShTens, mShUnits, mDispTens, mDispUnits;
  logic [6:0] segTab [0:15];

  always #5 clk = ~clk;

  bcd_sevenseg_scan #(
    .CLK_DIV (DIV),
    .CNT_W   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .tens_in    (tens_in),
    .units_in   (units_in),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    testsRun++;
    if (obs !== expVal) begin
      testsFailed++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h (t=%0t)", phase, tag, obs, expVal, $time);
    end
  endtask

  function automatic logic [6:0] expectSeg(input bit tensSlot, input logic [3:0] t, input logic [3:0] u);
    if (tensSlot) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (t == 4'd0) return 7'h7F;
`endif
      return segTab[t];
    end
    return segTab[u];
  endfunction

  // Drive one clock's inputs, predict the post-edge outputs from the frame model, then check.
  task automatic applyStimulus(input logic ld, input logic [3:0] t, input logic [3:0] u);
    logic [6:0] eSeg;
    logic [1:0] eAn;
    logic       eTick;
    bit         tensSlot;
    load     = ld;
    tens_in  = t;
    units_in = u;
    @(posedge clk);
    n++;
    tensSlot = (((n - 1) / DIV) % 2) == 1;
    eSeg  = expectSeg(tensSlot, mDispTens, mDispUnits);
    eAn   = tensSlot ? 2'b01 : 2'b10;
    eTick = (n % FRAME) == 0;
    if ((n % FRAME) == 0) begin
      if (ld) begin
        mDispTens  = t;
        mDispUnits = u;
      end else begin
        mDispTens  = mShTens;
        mDispUnits = mShUnits;
      end
    end
    if (ld) begin
      mShTens  = t;
      mShUnits = u;
    end
    #1;
    load = 1'b0;
    checkOutput("seg", 32'(seg), 32'(eSeg));
    checkOutput("an", 32'(an), 32'(eAn));
    checkOutput("frame_tick", 32'(frame_tick), 32'(eTick));
    if (frame_tick === 1'b1) begin
      if (lastTick >= 0) checkOutput("tick_period", 32'(n - lastTick), 32'(FRAME));
      lastTick = n;
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  task automatic resetDut(input int cycles);
    #3;
    rst  = 1'b1;
    load = 1'b0;
    #1;
    checkOutput("rst_async_seg", 32'(seg), 32'h7F);
    checkOutput("rst_async_an", 32'(an), 32'h3);
    checkOutput("rst_async_tick", 32'(frame_tick), 32'h0);
    repeat (cycles) @(posedge clk);
    #1;
    checkOutput("rst_hold_seg", 32'(seg), 32'h7F);
    checkOutput("rst_hold_an", 32'(an), 32'h3);
    rst        = 1'b0;
    n          = 0;
    lastTick   = -1;
    mShTens    = 4'd0;
    mShUnits   = 4'd0;
    mDispTens  = 4'd0;
    mDispUnits = 4'd0;
  endtask

  initial begin
    segTab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    rst      = 1'b1;
    load     = 1'b0;
    tens_in  = 4'd0;
    units_in = 4'd0;
    n        = 0;
    lastTick = -1;

    phase = "reset";
    resetDut(3);

    phase = "load15";
    applyStimulus(1'b0, 4'd0, 4'd0);
    applyStimulus(1'b1, 4'd1, 4'd5);
    repeat (22) idle();

    phase = "dash";
    applyStimulus(1'b1, 4'd1, 4'hC);
    repeat (16) idle();

    phase = "zero_tens";
    applyStimulus(1'b1, 4'd0, 4'd7);
    repeat (16) idle();

    phase = "bypass";
    while (((n + 1) % FRAME) != 0) idle();
    applyStimulus(1'b1, 4'd1, 4'd9);
    repeat (2) idle();
    applyStimulus(1'b1, 4'd0, 4'd3);
    idle();
    applyStimulus(1'b1, 4'd0, 4'd6);
    repeat (20) idle();

    phase = "mid_reset";
    while ((n % FRAME) != 6) idle();
    resetDut(2);
    repeat (20) idle();

    phase = "random";
    for (int i = 0; i < 1000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bcd_sevenseg_scan.md
Name: bcd_sevenseg_scan

Overview:
- Time-multiplexed two-digit seven-segment driver, downstream of the binary-to-BCD converter.
- Latches a tens/units BCD pair on a load strobe and scans it onto a common-anode two-digit display through a refresh divider.
- Updates the displayed pair only at frame boundaries, so a digit never shows half-old, half-new values.

Parameters:
- CLK_DIV, 100000, clk cycles per digit slot; legal 2..2^20; tick when the divider reaches CLK_DIV-1.
- CNT_W, 20, divider counter width; must satisfy 2^CNT_W >= CLK_DIV.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle strobe; captures tens_in/units_in.
- tens_in  in  4  tens BCD digit (0..9; the upstream converter only produces 0/1).
- units_in  in  4  units BCD digit (0..9).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  out  2  digit enables, active-low, registered; an[0]=units, an[1]=tens.
- frame_tick  out  1  one-cycle pulse when a new frame starts (display regs reloaded).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - seg=7'h7F, an=2'b11, frame_tick=0.
  - Divider=0, state=DIG_UNITS.
  - shadow_tens/units=0, disp_tens/units=0.
- Divider: increments every clk; at CLK_DIV-1 it asserts internal tick and wraps to 0 on the same edge.
- FSM, two states:
  - DIG_UNITS: on tick -> DIG_TENS.
  - DIG_TENS: on tick -> DIG_UNITS, and disp regs <- shadow regs, frame_tick=1 for that cycle.
- Load:
  - On load=1, shadow regs <- inputs at that edge.
  - If load coincides with the DIG_TENS->DIG_UNITS reload, disp regs take the new input values (bypass), not the old shadow.
  - Back-to-back loads: last one before a frame boundary wins.
- Output stage:
  - seg/an registered from state and disp regs; one-cycle latency after a state change.
  - Exactly one an bit low at any time after the first post-reset edge.
  - No both-low overlap, ever.
- Decode, active-low seg:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Any value 10..15 shows a dash, 3F (g only).
- Reset mid-frame: all state returns to reset values immediately (asynchronous); seg/an go blank/off without waiting for clk.
- Post-reset display: first frame shows 00, since disp regs are 0; the first loaded value appears after the first DIG_TENS->DIG_UNITS transition.
- Frame period: 2*CLK_DIV cycles; first frame_tick at cycle 2*CLK_DIV after reset release.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when disp_tens==0, the tens slot drives seg=7F while an[1] still cycles normally. The units digit is never blanked.
- Undefined: the tens slot shows 0 (40) like any other digit.
- Macro state has no effect on timing, frame_tick or an sequencing.

Decomposition:
- Package sevenseg_pkg:
  - Localparams SEG_0..SEG_9, SEG_DASH=7'h3F, SEG_BLANK=7'h7F.
  - Digit-state typedef/encoding DIG_UNITS=1'b0, DIG_TENS=1'b1.
  - AN_OFF=2'b11.
- Sub-module bcd_to_seg7: purely combinational 4-bit -> 7-bit active-low decoder, instantiated once on the digit mux output.
- Divider, FSM, shadow/display regs and output regs stay in bcd_sevenseg_scan.

Test Plan (CLK_DIV=4):
- Reset hold 3 cycles, release -> seg=7F, an=11 during reset; after first edge, an=10; an toggles every 4 cycles; frame_tick at cycle 8.
- Load tens=1, units=5 at cycle 2 -> display stays 00 until the frame boundary; next frame units slot seg=12, tens slot seg=79.
- Load units=4'hC -> units slot shows 3F; load tens=0, units=7 -> tens slot shows 7F with LEADING_ZERO_BLANK_EN, 40 without; units slot 78.
- Load asserted in the exact reload cycle with tens=1, units=9 -> that frame shows 1/9 (bypass); loads 3 then 6 within one frame -> only 6 is displayed.
- Assert rst mid-DIG_TENS -> seg/an go 7F/11 asynchronously before the next clk edge; after release, divider restarts and first frame shows 00.
- Check over 1000 cycles with random loads -> an never equals 00, frame_tick period is always 8, and seg changes only one cycle after an an transition or reload.
